sha256_digest_serializer: RTL
=============================

Name: sha256_digest_serializer

Overview:
- Consumer end of the compression core's digest interface.
- Collects the eight final hash words the core presents serially (valid strobe plus word index 0..7) into a 256-bit digest register.
- Streams the digest out as 32 bytes over a valid/ready byte interface toward the host link.
- Also exposes the full 256-bit digest in parallel for on-chip consumers.

Parameters:
DATA_WIDTH, 32, width of one hash word
NUM_WORDS, 8, hash words per digest
BYTE_WIDTH, 8, width of the output byte stream

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low, sampled on rising edge of clk
word_in  input  DATA_WIDTH  hash word from the compression core
word_dv_in  input  1  word_in/word_idx_in valid this cycle
word_idx_in  input  7  index of word_in (0 = H0 ... 7 = H7)
byte_out  output  BYTE_WIDTH  current output byte
byte_valid_out  output  1  byte_out valid
byte_ready_in  input  1  downstream accepts byte_out this cycle
digest_out  output  NUM_WORDS*DATA_WIDTH  assembled digest; word 0 in bits [255:224]
digest_valid_out  output  1  digest_out complete and stable
busy_out  output  1  state is SEND
done_out  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (rst_n low at a clk edge):
  - state to IDLE; received mask, byte counter and digest register to 0.
  - All outputs to 0.
  - Reset mid-CAPTURE or mid-SEND abandons the digest; no done_out.
- States:
  - IDLE
  - CAPTURE
  - SEND
  - DONE
- IDLE:
  - word_dv_in=1 with word_idx_in<8: store the word and set its mask bit, go to CAPTURE.
  - The same accept also clears digest_valid_out.
- CAPTURE:
  - word_dv_in=1 with word_idx_in<8: store word_in into slot word_idx_in and set its mask bit.
  - A duplicate index overwrites the slot; the mask bit stays set.
  - word_idx_in>=8 is ignored in every state.
  - Mask becomes all-ones at the edge E that stores the last missing word: at that edge go to SEND, clear the byte counter, set digest_valid_out=1.
  - byte_valid_out=1 from cycle E+1, showing byte 0.
  - Word arrival order is free.
- SEND:
  - byte_out = digest byte selected by the counter, big-endian: counter 0 = word0[31:24], counter 3 = word0[7:0], counter 31 = word7[7:0].
  - byte_valid_out=1 throughout SEND.
  - Transfer occurs on a cycle with byte_valid_out & byte_ready_in; the counter then increments.
  - While ready is low, byte_out is held stable.
  - word_dv_in is ignored; the digest register is frozen.
  - A transfer at counter 31 goes to DONE; byte_valid_out drops the next cycle.
- DONE (one cycle):
  - done_out=1, then go to IDLE with the mask cleared.
  - digest_out/digest_valid_out stay asserted until the next accepted word in IDLE.
- busy_out=1 exactly while state==SEND.
- byte_out=0 when byte_valid_out=0.
- Minimum drain is 32 cycles from first byte_valid_out with ready held high.
- All outputs are registered.
- Counter width is 5 bits; no wrap occurs because the exit happens at 31.

Test Plan:
- SHA-256("abc"): words 0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad on consecutive cycles, ready=1 -> digest_out equals the concatenation; byte stream ba,78,16,bf,...,15,ad over 32 consecutive cycles; done_out one pulse one cycle after the last byte is accepted.
- Out-of-order capture: indices 7,3,0,1,2,6,5,4 with the same values -> identical digest_out and byte stream; SEND entered only after index 4 arrives.
- Backpressure: byte_ready_in toggles 1,0,0,1 repeating -> byte_out stable during stalls, all 32 bytes delivered in order, no duplicates or losses.
- Illegal/duplicate input: word_idx_in=9 with word_in=deadbeef at any time -> no effect; index 2 sent twice (11111111 then 414140de) -> 414140de in the output. word_dv_in pulses during SEND -> stream unchanged.
- Reset mid-SEND: rst_n low after byte 10 is accepted -> next cycle byte_valid_out=0, digest_valid_out=0, busy_out=0, no done_out; a fresh 8-word capture afterwards streams correctly from byte 0.
- Back-to-back digests: second digest's word 0 arrives the cycle after done_out -> digest_valid_out falls on that edge, second stream is correct, the first digest is not re-emitted.

Source files
------------

// File: rtl/sha256_digest_serializer.sv
// Collects the eight SHA-256 hash words from the compression core into a
// 256-bit digest register. It presents the digest in parallel and streams it
// out big-endian as 32 bytes over a valid/ready byte interface.
module sha256_digest_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           word_in,
  input  logic                            word_dv_in,
  input  logic [6:0]                      word_idx_in,
  output logic [BYTE_WIDTH-1:0]           byte_out,
  output logic                            byte_valid_out,
  input  logic                            byte_ready_in,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] digest_out,
  output logic                            digest_valid_out,
  output logic                            busy_out,
  output logic                            done_out
);

  localparam int DIG_W     = NUM_WORDS * DATA_WIDTH;
  localparam int NUM_BYTES = DIG_W / BYTE_WIDTH;
  localparam int CNT_W     = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

  state_t                 state, state_nx;
  logic [NUM_WORDS-1:0]   mask, mask_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [DIG_W-1:0]       digest_nx;
  logic                   dig_vld_nx;
  logic                   word_ok;
  logic [BYTE_WIDTH-1:0]  byte_nx;

  // Big-endian byte pick: byte 0 is the top byte of word 0.
  function automatic logic [BYTE_WIDTH-1:0] sel_byte(input logic [DIG_W-1:0] d,
                                                     input logic [CNT_W-1:0] k);
    logic [BYTE_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (k == i[CNT_W-1:0]) b = d[DIG_W-1-i*BYTE_WIDTH -: BYTE_WIDTH];
    end
    return b;
  endfunction

  // Next-state, capture and streaming decisions; outputs are registered from these.
  always_comb begin
    state_nx   = state;
    mask_nx    = mask;
    cnt_nx     = cnt;
    digest_nx  = digest_out;
    dig_vld_nx = digest_valid_out;
    word_ok    = word_dv_in && (word_idx_in < 7'(NUM_WORDS));
    case (state)
      IDLE, CAPTURE: begin
        if (word_ok) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_idx_in == i[6:0]) begin
              digest_nx[DIG_W-1-i*DATA_WIDTH -: DATA_WIDTH] = word_in;
              mask_nx[i] = 1'b1;
            end
          end
          // A new digest starts: the previous one is no longer valid.
          dig_vld_nx = 1'b0;
          state_nx   = CAPTURE;
          if (&mask_nx) begin
            state_nx   = SEND;
            cnt_nx     = '0;
            dig_vld_nx = 1'b1;
          end
        end
      end
      SEND: begin
        // byte_valid_out is high for all of SEND, so ready alone marks a transfer.
        if (byte_ready_in) begin
          if (cnt == LAST_BYTE) state_nx = DONE;
          else                  cnt_nx   = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        mask_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
    byte_nx = (state_nx == SEND) ? sel_byte(digest_nx, cnt_nx) : '0;
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      mask             <= '0;
      cnt              <= '0;
      digest_out       <= '0;
      digest_valid_out <= 1'b0;
      byte_out         <= '0;
      byte_valid_out   <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      state            <= state_nx;
      mask             <= mask_nx;
      cnt              <= cnt_nx;
      digest_out       <= digest_nx;
      digest_valid_out <= dig_vld_nx;
      byte_out         <= byte_nx;
      byte_valid_out   <= (state_nx == SEND);
      busy_out         <= (state_nx == SEND);
      done_out         <= (state_nx == DONE);
    end
  end

endmodule
